halfband_rate_sequencer: RTL and testbench

Clock-enable generator and run sequencer for the 2x halfband interpolation stage. It derives the phase-aligned `clock_12_5_en`, `sam_clk_en` and `sym_clk_en` strobes from the system clock, and drives the polyphase select so the filter output alternates between branches in lockstep. It also sequences start-up priming and stop-time zero-fill flushing of the filter delay line, and flags when filter output is valid. It sits between the top-level control (start/stop) and the halfband datapath plus its upstream symbol source.

---
 rtl/halfband_rate_sequencer.sv | 169 ++++++++++++++++
 tb/tb_halfband_rate_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/halfband_rate_sequencer.sv
// -----------------------------------------------------------------------------
// halfband_rate_sequencer
//
// Clock-enable generator and run sequencer for the 2x halfband interpolation
// stage. A single free-running phase counter (active outside IDLE) is decoded
// into three phase-aligned strobes:
//   clock_12_5_en : output-rate strobe, once every DIV_FAST clk cycles
//   sam_clk_en    : input-sample strobe, once every 2*DIV_FAST clk cycles
//   sym_clk_en    : symbol strobe, once every SPS samples
// The polyphase select `phase` toggles on every output-rate strobe, so the
// filter output alternates direct branch (0) / FIR branch (1) in lockstep with
// the input samples.
//
// The sequencer primes the filter delay line after start (PRIME), runs
// (RUN), and on stop flushes the delay line with zero-filled samples (DRAIN)
// before returning to IDLE.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   start         in   level-sampled run request (honoured only in IDLE)
//   stop          in   level-sampled stop request (beats start, ignored in IDLE)
//   clock_12_5_en out  output-rate strobe
//   sam_clk_en    out  input-sample strobe
//   sym_clk_en    out  symbol strobe
//   phase         out  polyphase select, 0 = direct branch, 1 = FIR branch
//   zero_fill     out  datapath substitutes 0 for x_in while high (DRAIN)
//   out_valid     out  filter output is meaningful
//   busy          out  sequencer is not IDLE
//   state         out  IDLE=0, PRIME=1, RUN=2, DRAIN=3
// -----------------------------------------------------------------------------
module halfband_rate_sequencer #(
    parameter int DIV_FAST      = 4,
    parameter int SPS           = 4,
    parameter int PRIME_SAMPLES = 4,
    parameter int FLUSH_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    output logic       clock_12_5_en,
    output logic       sam_clk_en,
    output logic       sym_clk_en,
    output logic       phase,
    output logic       zero_fill,
    output logic       out_valid,
    output logic       busy,
    output logic [1:0] state
);

    // One full symbol period in clk cycles; the phase counter wraps here.
    localparam int P    = 2 * DIV_FAST * SPS;
    localparam int CW   = (P > 1) ? $clog2(P) : 1;
    localparam int SMAX = (PRIME_SAMPLES > FLUSH_SAMPLES) ? PRIME_SAMPLES : FLUSH_SAMPLES;
    localparam int SW   = ($clog2(SMAX + 1) < 3) ? 3 : $clog2(SMAX + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          phase_q,   phase_d;
    logic [SW-1:0] sampCnt_q, sampCnt_d;
    logic          fromRun_q, fromRun_d;

    logic active;

    // Strobes come only from registered counter and state, so start/stop can
    // never reach them combinationally. All strobes are quiet in IDLE because
    // the counter is parked at 0 there and the active qualifier is low.
    assign active        = (state_q != IDLE);
    assign clock_12_5_en = active && ((int'(cnt_q) % DIV_FAST) == (DIV_FAST - 1));
    assign sam_clk_en    = active && ((int'(cnt_q) % (2 * DIV_FAST)) == (2 * DIV_FAST - 1));
    assign sym_clk_en    = active && (cnt_q == CW'(P - 1));

    // Status decode. out_valid survives into DRAIN only when the filter had
    // actually been producing valid output, i.e. DRAIN was entered from RUN.
    assign phase     = phase_q;
    assign zero_fill = (state_q == DRAIN);
    assign out_valid = (state_q == RUN) || ((state_q == DRAIN) && fromRun_q);
    assign busy      = active;
    assign state     = state_q;

    // Sequencer next-state logic. stop is checked before any sample-count
    // completion so it always wins; start is looked at only in IDLE.
    always_comb begin
        state_d   = state_q;
        fromRun_d = fromRun_q;
        case (state_q)
            IDLE: begin
                fromRun_d = 1'b0;
                if (start && !stop) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (stop) begin
                    state_d   = DRAIN;
                    fromRun_d = 1'b0;
                end else if (sam_clk_en && (sampCnt_q == SW'(PRIME_SAMPLES - 1))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d   = DRAIN;
                    fromRun_d = 1'b1;
                end
            end
            default: begin
                if (sam_clk_en && (sampCnt_q == SW'(FLUSH_SAMPLES - 1))) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // The sample counter measures progress through PRIME and DRAIN only; it
    // restarts on every state change so each phase counts from zero. In RUN
    // it simply holds, since nothing there depends on it.
    always_comb begin
        sampCnt_d = sampCnt_q;
        if (state_d != state_q) begin
            sampCnt_d = '0;
        end else if (sam_clk_en && ((state_q == PRIME) || (state_q == DRAIN))) begin
            sampCnt_d = sampCnt_q + SW'(1);
        end
    end

    // Phase counter and polyphase select. Both keep running straight through
    // PRIME -> RUN -> DRAIN so the datapath sees no discontinuity at a stop;
    // they are parked at 0 whenever the sequencer is (or is about to be) idle,
    // which also makes cnt 0 in the first PRIME cycle.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if ((state_d == IDLE) || (state_q == IDLE)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else begin
            cnt_d = (cnt_q == CW'(P - 1)) ? '0 : (cnt_q + CW'(1));
            if (clock_12_5_en) begin
                phase_d = ~phase_q;
            end
        end
    end

    // State registers with asynchronous active-high reset; reset returns
    // everything to IDLE immediately and drops any pending request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            sampCnt_q <= '0;
            fromRun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            sampCnt_q <= sampCnt_d;
            fromRun_q <= fromRun_d;
        end
    end

endmodule

// File: tb/tb_halfband_rate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_halfband_rate_sequencer
//
// Self-checking bench for halfband_rate_sequencer. Two instances share one
// stimulus stream: instance 0 uses the default parameters (P = 32), instance 1
// uses DIV_FAST = 2, SPS = 2 (P = 8). A behavioural reference model tracks,
// per instance, the mode and the number of cycles elapsed since PRIME was
// entered; strobes and phase are computed from that elapsed time with plain
// modular arithmetic. Directed scenarios come first, then a randomized run.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_halfband_rate_sequencer;

    localparam int PRIME_N = 4;
    localparam int FLUSH_N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [1:0] ce;
    logic [1:0] sam;
    logic [1:0] sym;
    logic [1:0] ph;
    logic [1:0] zf;
    logic [1:0] ov;
    logic [1:0] bz;
    logic [1:0] st [2];

    int errors = 0;
    int checks = 0;

    // Reference model: mode (0..3), cycles since PRIME entry, samples seen in
    // the current mode, and whether DRAIN was entered from RUN.
    int mSt   [2];
    int mT    [2];
    int mScnt [2];
    bit mVld  [2];
    int mDiv  [2] = '{4, 2};
    int mSps  [2] = '{4, 2};

    // Free-running system clock, 10 time units per period.
    always #5 clk = ~clk;

    halfband_rate_sequencer dutA (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .clock_12_5_en (ce[0]),
        .sam_clk_en    (sam[0]),
        .sym_clk_en    (sym[0]),
        .phase         (ph[0]),
        .zero_fill     (zf[0]),
        .out_valid     (ov[0]),
        .busy          (bz[0]),
        .state         (st[0])
    );

    halfband_rate_sequencer #(
        .DIV_FAST      (2),
        .SPS           (2),
        .PRIME_SAMPLES (PRIME_N),
        .FLUSH_SAMPLES (FLUSH_N)
    ) dutB (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .clock_12_5_en (ce[1]),
        .sam_clk_en    (sam[1]),
        .sym_clk_en    (sym[1]),
        .phase         (ph[1]),
        .zero_fill     (zf[1]),
        .out_valid     (ov[1]),
        .busy          (bz[1]),
        .state         (st[1])
    );

    // Expected outputs for the current cycle of instance i, derived from the
    // elapsed time since PRIME entry: strobes are position-within-period
    // tests, phase is the parity of the number of output-rate strobes so far.
    function automatic void modelOut(input int i, output logic [1:0] eSt,
                                     output logic eCe, output logic eSam,
                                     output logic eSym, output logic ePh,
                                     output logic eZf, output logic eOv,
                                     output logic eBz);
        int p;
        p    = 2 * mDiv[i] * mSps[i];
        eSt  = 2'(mSt[i]);
        eCe  = 1'b0;
        eSam = 1'b0;
        eSym = 1'b0;
        ePh  = 1'b0;
        eZf  = 1'b0;
        eOv  = 1'b0;
        eBz  = 1'b0;
        if (mSt[i] != 0) begin
            eCe  = ((mT[i] % mDiv[i]) == mDiv[i] - 1);
            eSam = ((mT[i] % (2 * mDiv[i])) == 2 * mDiv[i] - 1);
            eSym = ((mT[i] % p) == p - 1);
            ePh  = (((mT[i] / mDiv[i]) % 2) == 1);
            eZf  = (mSt[i] == 3);
            eOv  = (mSt[i] == 2) || ((mSt[i] == 3) && mVld[i]);
            eBz  = 1'b1;
        end
    endfunction

    // Advance the model across one active clock edge with inputs s/p.
    task automatic modelEdge(input logic s, input logic p);
        logic [1:0] eSt;
        logic eCe, eSam, eSym, ePh, eZf, eOv, eBz;
        for (int i = 0; i < 2; i++) begin
            modelOut(i, eSt, eCe, eSam, eSym, ePh, eZf, eOv, eBz);
            case (mSt[i])
                0: begin
                    if (s && !p) begin
                        mSt[i]   = 1;
                        mT[i]    = 0;
                        mScnt[i] = 0;
                    end
                end
                1, 2: begin
                    if (p) begin
                        mVld[i]  = (mSt[i] == 2);
                        mSt[i]   = 3;
                        mScnt[i] = 0;
                    end else begin
                        if (eSam) mScnt[i]++;
                        if ((mSt[i] == 1) && (mScnt[i] == PRIME_N)) begin
                            mSt[i]   = 2;
                            mScnt[i] = 0;
                        end
                    end
                    mT[i]++;
                end
                default: begin
                    if (eSam) mScnt[i]++;
                    if (mScnt[i] == FLUSH_N) begin
                        mSt[i]   = 0;
                        mT[i]    = 0;
                        mScnt[i] = 0;
                    end else begin
                        mT[i]++;
                    end
                end
            endcase
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mSt[i]   = 0;
            mT[i]    = 0;
            mScnt[i] = 0;
            mVld[i]  = 1'b0;
        end
    endtask

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkVal(input string tag, input int i,
                            input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s inst=%0d observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic checkOutput();
        logic [1:0] eSt;
        logic eCe, eSam, eSym, ePh, eZf, eOv, eBz;
        for (int i = 0; i < 2; i++) begin
            modelOut(i, eSt, eCe, eSam, eSym, ePh, eZf, eOv, eBz);
            checkVal("state",         i, 32'(st[i]),  32'(eSt));
            checkVal("clock_12_5_en", i, 32'(ce[i]),  32'(eCe));
            checkVal("sam_clk_en",    i, 32'(sam[i]), 32'(eSam));
            checkVal("sym_clk_en",    i, 32'(sym[i]), 32'(eSym));
            checkVal("phase",         i, 32'(ph[i]),  32'(ePh));
            checkVal("zero_fill",     i, 32'(zf[i]),  32'(eZf));
            checkVal("out_valid",     i, 32'(ov[i]),  32'(eOv));
            checkVal("busy",          i, 32'(bz[i]),  32'(eBz));
        end
    endtask

    // One clk cycle: drive inputs after the falling edge, let the rising edge
    // sample them, then check outputs at the next falling edge.
    task automatic applyStimulus(input logic s, input logic p);
        start = s;
        stop  = p;
        @(posedge clk);
        modelEdge(s, p);
        @(negedge clk);
        checkOutput();
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    // A start held during reset is dropped before release so it must not
    // be remembered afterwards.
    task automatic pulseReset(input logic pendingStart);
        #2;
        start = pendingStart;
        stop  = 1'b0;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        checkOutput();
        start = 1'b0;
        reset = 1'b0;
    endtask

    // Start from IDLE with start held; checks the headline timing of the
    // default instance against fixed cycle numbers.
    task automatic scenarioOne();
        int firstCe, firstSam, firstSym, firstOv;
        firstCe  = -1;
        firstSam = -1;
        firstSym = -1;
        firstOv  = -1;
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            if (ce[0]  && firstCe  < 0) firstCe  = k;
            if (sam[0] && firstSam < 0) firstSam = k;
            if (sym[0] && firstSym < 0) firstSym = k;
            if (ov[0]  && firstOv  < 0) firstOv  = k;
            if (k == 1)  checkVal("state_k1",       0, 32'(st[0]), 32'd1);
            if (k == 5)  checkVal("phase_after_k4", 0, 32'(ph[0]), 32'd1);
            if (k == 9)  checkVal("phase_after_k8", 0, 32'(ph[0]), 32'd0);
            if (k == 32) checkVal("state_k32",      0, 32'(st[0]), 32'd1);
            if (k == 33) checkVal("state_k33",      0, 32'(st[0]), 32'd2);
            applyStimulus(1'b1, 1'b0);
        end
        checkVal("first_ce_k",  0, firstCe,  32'd4);
        checkVal("first_sam_k", 0, firstSam, 32'd8);
        checkVal("first_sym_k", 0, firstSym, 32'd32);
        checkVal("first_ov_k",  0, firstOv,  32'd33);
    endtask

    initial begin
        int nCe, nSam, nSym, nDrainSam, guard, r;

        $display("[TB] halfband_rate_sequencer bench starting");
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput();
        @(negedge clk);
        checkOutput();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // Start-up timing with start held high.
        scenarioOne();

        // Steady RUN over three symbol periods with start pulses sprinkled in.
        nCe  = 0;
        nSam = 0;
        nSym = 0;
        for (int j = 0; j < 96; j++) begin
            if (ce[0])  nCe++;
            if (sam[0]) nSam++;
            if (sym[0]) begin
                nSym++;
                checkVal("sym_aligned", 0, 32'({sam[0], ce[0]}), 32'd3);
            end
            applyStimulus((j % 7) == 0, 1'b0);
        end
        checkVal("run_ce_count",  0, nCe,  32'd24);
        checkVal("run_sam_count", 0, nSam, 32'd12);
        checkVal("run_sym_count", 0, nSym, 32'd3);

        // Stop pulse mid-RUN, with a start pulse during DRAIN.
        applyStimulus(1'b0, 1'b1);
        checkVal("drain_entered",     0, 32'(st[0]), 32'd3);
        checkVal("ov_drain_from_run", 0, 32'(ov[0]), 32'd1);
        nDrainSam = 0;
        for (int j = 0; j < 50; j++) begin
            if ((st[0] == 2'd3) && sam[0]) nDrainSam++;
            applyStimulus(j == 2, 1'b0);
        end
        checkVal("drain_sam_count", 0, nDrainSam, 32'd4);
        checkVal("idle_after_drain", 0, 32'(st[0]), 32'd0);

        // start and stop together in IDLE must not leave IDLE.
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 1'b1);
            checkVal("idle_start_stop", 0, 32'(st[0]), 32'd0);
            checkVal("idle_start_stop", 1, 32'(st[1]), 32'd0);
        end

        // Stop during PRIME at k = 10.
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k < 10; k++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkVal("prime_stop_drain", 0, 32'(st[0]), 32'd3);
        checkVal("prime_stop_ov",    0, 32'(ov[0]), 32'd0);
        for (int k = 11; k <= 45; k++) begin
            if (k == 40) checkVal("prime_drain_k40", 0, 32'(st[0]), 32'd3);
            if (k == 41) checkVal("prime_drain_k41", 0, 32'(st[0]), 32'd0);
            applyStimulus(1'b0, 1'b0);
        end

        // Reset at RUN cnt = 13, then restart must reproduce start-up timing.
        applyStimulus(1'b1, 1'b0);
        guard = 0;
        while (!((mSt[0] == 2) && ((mT[0] % 32) == 13)) && (guard < 200)) begin
            applyStimulus(1'b0, 1'b0);
            guard++;
        end
        checkVal("run_before_reset", 0, 32'(st[0]), 32'd2);
        pulseReset(1'b1);
        applyStimulus(1'b0, 1'b0);
        checkVal("no_pending_start", 0, 32'(st[0]), 32'd0);
        checkVal("no_pending_start", 1, 32'(st[1]), 32'd0);
        scenarioOne();
        applyStimulus(1'b0, 1'b1);
        for (int j = 0; j < 40; j++) applyStimulus(1'b0, 1'b0);

        // Randomized traffic with occasional asynchronous resets.
        for (int j = 0; j < 3000; j++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                pulseReset(1'($urandom_range(0, 1)));
            end else begin
                applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
